// File: rtl/execute_stage_if.sv
// ---------------------------------------------------------------------------
// execute_stage_if
// Bundles the signals between the ID/EX register, the execute stage and the
// EX/MEM register of the RV32I pipeline.
//   E-side inputs : EnM, ID/EX controls (RegWriteE, MemWriteE, JumpE,
//                   BranchE, ALUSrcE, JalrE, ResultSrcE, ALUControlE,
//                   funct3E), ID/EX data (PCE, PCPlus4E, ImmExtE, RD1E, RD2E,
//                   RdE), forwarding selects (ForwardAE, ForwardBE) and
//                   ResultW
//   Outputs       : PCSrcE, PCTargetE, ZeroE (combinational) and the EX/MEM
//                   register contents (RegWriteM, MemWriteM, ResultSrcM,
//                   funct3M, RdM, ALUResultM, WriteDataM, PCPlus4M)
// Modports: master = pipeline/upstream driver, slave = execute stage.
// ---------------------------------------------------------------------------
interface execute_stage_if;
   logic        EnM;
   logic        RegWriteE;
   logic        MemWriteE;
   logic        JumpE;
   logic        BranchE;
   logic        ALUSrcE;
   logic        JalrE;
   logic [1:0]  ResultSrcE;
   logic [4:0]  ALUControlE;
   logic [2:0]  funct3E;
   logic [31:0] PCE;
   logic [31:0] PCPlus4E;
   logic [31:0] ImmExtE;
   logic [31:0] RD1E;
   logic [31:0] RD2E;
   logic [4:0]  RdE;
   logic [1:0]  ForwardAE;
   logic [1:0]  ForwardBE;
   logic [31:0] ResultW;

   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        ZeroE;
   logic        RegWriteM;
   logic        MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  funct3M;
   logic [4:0]  RdM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] PCPlus4M;

   modport master (
      output EnM, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE,
             ResultSrcE, ALUControlE, funct3E, PCE, PCPlus4E, ImmExtE,
             RD1E, RD2E, RdE, ForwardAE, ForwardBE, ResultW,
      input  PCSrcE, PCTargetE, ZeroE, RegWriteM, MemWriteM, ResultSrcM,
             funct3M, RdM, ALUResultM, WriteDataM, PCPlus4M
   );

   modport slave (
      input  EnM, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE,
             ResultSrcE, ALUControlE, funct3E, PCE, PCPlus4E, ImmExtE,
             RD1E, RD2E, RdE, ForwardAE, ForwardBE, ResultW,
      output PCSrcE, PCTargetE, ZeroE, RegWriteM, MemWriteM, ResultSrcM,
             funct3M, RdM, ALUResultM, WriteDataM, PCPlus4M
   );
endinterface

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// RV32I execute stage: operand forwarding, ALU, branch resolution and the
// EX/MEM pipeline register.
//   clk  : pipeline clock, all state updates on the rising edge
//   rst  : synchronous active-low reset of the EX/MEM register
//   bus  : execute_stage_if.slave -- ID/EX inputs, forwarding sources,
//          combinational branch outputs and EX/MEM register contents
// ---------------------------------------------------------------------------
module execute_stage (
   input  logic               clk,
   input  logic               rst,
   execute_stage_if.slave     bus
);

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;
   localparam logic [4:0] ALU_AND  = 5'b00010;
   localparam logic [4:0] ALU_OR   = 5'b00011;
   localparam logic [4:0] ALU_XOR  = 5'b00100;
   localparam logic [4:0] ALU_SLL  = 5'b00101;
   localparam logic [4:0] ALU_SRL  = 5'b00110;
   localparam logic [4:0] ALU_SRA  = 5'b00111;
   localparam logic [4:0] ALU_SLT  = 5'b01000;
   localparam logic [4:0] ALU_SLTU = 5'b01001;
   localparam logic [4:0] ALU_LUI  = 5'b01010;

   logic [31:0] w_src_a;
   logic [31:0] w_write_data;
   logic [31:0] w_src_b;
   logic [4:0]  w_shamt;
   logic [31:0] w_alu_result;
   logic        w_cond;

   logic        r_reg_write;
   logic        r_mem_write;
   logic [1:0]  r_result_src;
   logic [2:0]  r_funct3;
   logic [4:0]  r_rd;
   logic [31:0] r_alu_result;
   logic [31:0] r_write_data;
   logic [31:0] r_pc_plus4;

   // Forwarding muxes; select 11 is unused by the hazard unit and falls back
   // to the register-file value.
   // NOTE: every always_comb output gets a default before the case so that no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      w_src_a = bus.RD1E;
      case (bus.ForwardAE)
         2'b01:   w_src_a = bus.ResultW;
         2'b10:   w_src_a = r_alu_result;
         default: w_src_a = bus.RD1E;
      endcase
   end

   always_comb begin
      w_write_data = bus.RD2E;
      case (bus.ForwardBE)
         2'b01:   w_write_data = bus.ResultW;
         2'b10:   w_write_data = r_alu_result;
         default: w_write_data = bus.RD2E;
      endcase
   end

   assign w_src_b = bus.ALUSrcE ? bus.ImmExtE : w_write_data;
   assign w_shamt = w_src_b[4:0];

   always_comb begin
      w_alu_result = 32'd0;
      case (bus.ALUControlE)
         ALU_ADD:  w_alu_result = w_src_a + w_src_b;
         ALU_SUB:  w_alu_result = w_src_a - w_src_b;
         ALU_AND:  w_alu_result = w_src_a & w_src_b;
         ALU_OR:   w_alu_result = w_src_a | w_src_b;
         ALU_XOR:  w_alu_result = w_src_a ^ w_src_b;
         ALU_SLL:  w_alu_result = w_src_a << w_shamt;
         ALU_SRL:  w_alu_result = w_src_a >> w_shamt;
         ALU_SRA:  w_alu_result = $unsigned($signed(w_src_a) >>> w_shamt);
         ALU_SLT:  w_alu_result = {31'd0, $signed(w_src_a) < $signed(w_src_b)};
         ALU_SLTU: w_alu_result = {31'd0, w_src_a < w_src_b};
         ALU_LUI:  w_alu_result = w_src_b;
         default:  w_alu_result = 32'd0;
      endcase
   end

   // Branch compares use the forwarded rs2 value, never the immediate.
   always_comb begin
      w_cond = 1'b0;
      case (bus.funct3E)
         3'b000:  w_cond = (w_src_a == w_write_data);
         3'b001:  w_cond = (w_src_a != w_write_data);
         3'b100:  w_cond = ($signed(w_src_a) <  $signed(w_write_data));
         3'b101:  w_cond = ($signed(w_src_a) >= $signed(w_src_b == w_src_b ? w_write_data : w_write_data));
         3'b110:  w_cond = (w_src_a <  w_write_data);
         3'b111:  w_cond = (w_src_a >= w_write_data);
         default: w_cond = 1'b0;
      endcase
   end

   assign bus.PCSrcE    = bus.JumpE | (bus.BranchE & w_cond);
   assign bus.PCTargetE = bus.JalrE ? ((w_src_a + bus.ImmExtE) & 32'hFFFF_FFFE)
                                    : (bus.PCE + bus.ImmExtE);
   assign bus.ZeroE     = (w_alu_result == 32'd0);

   // EX/MEM register: reset beats stall, stall beats load.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_reg_write  <= 1'b0;
         r_mem_write  <= 1'b0;
         r_result_src <= 2'd0;
         r_funct3     <= 3'd0;
         r_rd         <= 5'd0;
         r_alu_result <= 32'd0;
         r_write_data <= 32'd0;
         r_pc_plus4   <= 32'd0;
      end else if (bus.EnM) begin
         r_reg_write  <= bus.RegWriteE;
         r_mem_write  <= bus.MemWriteE;
         r_result_src <= bus.ResultSrcE;
         r_funct3     <= bus.funct3E;
         r_rd         <= bus.RdE;
         r_alu_result <= w_alu_result;
         r_write_data <= w_write_data;
         r_pc_plus4   <= bus.PCPlus4E;
      end
   end

   assign bus.RegWriteM  = r_reg_write;
   assign bus.MemWriteM  = r_mem_write;
   assign bus.ResultSrcM = r_result_src;
   assign bus.funct3M    = r_funct3;
   assign bus.RdM        = r_rd;
   assign bus.ALUResultM = r_alu_result;
   assign bus.WriteDataM = r_write_data;
   assign bus.PCPlus4M   = r_pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
// Self-checking bench for execute_stage: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the execute stage and its EX/MEM register.
// ---------------------------------------------------------------------------
module tb_execute_stage;

   localparam logic [31:0] MSB = 32'h8000_0000;

   logic clk;
   logic rst;
   execute_stage_if bus ();

   execute_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int  n_cmp  = 0;
   int  n_fail = 0;
   bit  chk_en = 1'b0;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] tgt;
      logic        pcsrc;
      logic        zero;
   } e_res_t;

   // Model EX/MEM state
   logic [31:0] m_alu, m_wd, m_pc4;
   logic [4:0]  m_rd;
   logic [2:0]  m_f3;
   logic [1:0]  m_rs;
   logic        m_rw, m_mw;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rd,
                                        input logic [31:0] w, input logic [31:0] m);
      if (sel == 2'b01) return w;
      if (sel == 2'b10) return m;
      return rd;
   endfunction

   // Execute-stage behaviour from first principles; fwd_m is the model's own
   // ALUResultM.
   function automatic e_res_t model_e(input logic [31:0] fwd_m);
      e_res_t      r;
      logic [31:0] a, b;
      int          sh;
      logic        c;
      a  = pick(bus.ForwardAE, bus.RD1E, bus.ResultW, fwd_m);
      r.wd = pick(bus.ForwardBE, bus.RD2E, bus.ResultW, fwd_m);
      b  = bus.ALUSrcE ? bus.ImmExtE : r.wd;
      sh = int'(b % 32);
      case (bus.ALUControlE)
         5'd0:    r.alu = a + b;
         5'd1:    r.alu = a + ~b + 32'd1;
         5'd2:    r.alu = a & b;
         5'd3:    r.alu = a | b;
         5'd4:    r.alu = a ^ b;
         5'd5:    r.alu = a << sh;
         5'd6:    r.alu = a >> sh;
         5'd7:    r.alu = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         5'd8:    r.alu = ((a ^ MSB) < (b ^ MSB)) ? 32'd1 : 32'd0;
         5'd9:    r.alu = (a < b) ? 32'd1 : 32'd0;
         5'd10:   r.alu = b;
         default: r.alu = 32'd0;
      endcase
      case (bus.funct3E)
         3'd0:    c = (a == r.wd);
         3'd1:    c = (a != r.wd);
         3'd4:    c = ((a ^ MSB) <  (r.wd ^ MSB));
         3'd5:    c = ((a ^ MSB) >= (r.wd ^ MSB));
         3'd6:    c = (a <  r.wd);
         3'd7:    c = (a >= r.wd);
         default: c = 1'b0;
      endcase
      r.pcsrc = bus.JumpE || (bus.BranchE && c);
      r.tgt   = bus.JalrE ? {a[31:1] + bus.ImmExtE[31:1] + {30'd0, a[0] & bus.ImmExtE[0]}, 1'b0}
                          : bus.PCE + bus.ImmExtE;
      r.zero  = (r.alu == 32'd0);
      return r;
   endfunction

   always @(posedge clk) begin
      e_res_t r;
      r = model_e(m_alu);
      if (!rst) begin
         m_alu <= '0; m_wd <= '0; m_pc4 <= '0; m_rd <= '0;
         m_f3 <= '0; m_rs <= '0; m_rw <= 1'b0; m_mw <= 1'b0;
      end else if (bus.EnM) begin
         m_alu <= r.alu;          m_wd <= r.wd;
         m_pc4 <= bus.PCPlus4E;   m_rd <= bus.RdE;
         m_f3  <= bus.funct3E;    m_rs <= bus.ResultSrcE;
         m_rw  <= bus.RegWriteE;  m_mw <= bus.MemWriteE;
      end
   end

   // Per-cycle comparison, away from the rising edge
   always @(negedge clk) begin
      e_res_t r;
      if (chk_en) begin
         r = model_e(m_alu);
         check("ALUResultM", bus.ALUResultM, m_alu);
         check("WriteDataM", bus.WriteDataM, m_wd);
         check("PCPlus4M",   bus.PCPlus4M,   m_pc4);
         check("ctrlM", {20'd0, bus.RdM, bus.funct3M, bus.ResultSrcM, bus.RegWriteM, bus.MemWriteM},
                        {20'd0, m_rd, m_f3, m_rs, m_rw, m_mw});
         check("PCTargetE",  bus.PCTargetE,  r.tgt);
         check("PCSrcE",     {31'd0, bus.PCSrcE}, {31'd0, r.pcsrc});
         check("ZeroE",      {31'd0, bus.ZeroE},  {31'd0, r.zero});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.EnM = 1'b1; bus.RegWriteE = 1'b0; bus.MemWriteE = 1'b0; bus.JumpE = 1'b0;
      bus.BranchE = 1'b0; bus.ALUSrcE = 1'b0; bus.JalrE = 1'b0; bus.ResultSrcE = 2'd0;
      bus.ALUControlE = 5'd0; bus.funct3E = 3'd0; bus.PCE = '0; bus.PCPlus4E = '0;
      bus.ImmExtE = '0; bus.RD1E = '0; bus.RD2E = '0; bus.RdE = '0;
      bus.ForwardAE = 2'd0; bus.ForwardBE = 2'd0; bus.ResultW = '0;
   endtask

   task automatic alu_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit use_imm);
      idle();
      bus.ALUControlE = op;
      bus.RD1E = a;
      if (use_imm) begin bus.ALUSrcE = 1'b1; bus.ImmExtE = b; end
      else bus.RD2E = b;
   endtask

   initial begin
      idle();
      rst = 1'b0;
      tick(); tick();
      chk_en = 1'b1;

      // Reset clears preloaded state
      rst = 1'b1;
      bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1; bus.ResultSrcE = 2'd2; bus.funct3E = 3'd5;
      bus.RdE = 5'd9; bus.RD1E = 32'h55; bus.RD2E = 32'h66; bus.PCPlus4E = 32'h44;
      tick();
      check("preload", bus.ALUResultM, 32'hBB);
      rst = 1'b0;
      tick();
      check("rst_alu", bus.ALUResultM, 32'd0);
      check("rst_wd",  bus.WriteDataM, 32'd0);
      check("rst_pc4", bus.PCPlus4M,   32'd0);
      check("rst_ctl", {22'd0, bus.RdM, bus.funct3M, bus.RegWriteM, bus.MemWriteM},  32'd0);
      rst = 1'b1;
      alu_op(5'b00000, 32'd5, 32'd7, 1'b0);
      tick();
      check("add_5_7", bus.ALUResultM, 32'd12);

      // ALU sweep
      alu_op(5'b00001, 32'd0, 32'd1, 1'b0);            tick();
      check("sub_0_1", bus.ALUResultM, 32'hFFFF_FFFF);
      alu_op(5'b00111, 32'h8000_0000, 32'd4, 1'b1);    tick();
      check("sra",     bus.ALUResultM, 32'hF800_0000);
      alu_op(5'b01000, 32'hFFFF_FFFF, 32'd1, 1'b0);    tick();
      check("slt",     bus.ALUResultM, 32'd1);
      alu_op(5'b01001, 32'hFFFF_FFFF, 32'd1, 1'b0);    tick();
      check("sltu",    bus.ALUResultM, 32'd0);
      alu_op(5'b11111, 32'h1234, 32'h5678, 1'b0);      #1;
      check("zero_e",  {31'd0, bus.ZeroE}, 32'd1);
      tick();
      check("op_1f",   bus.ALUResultM, 32'd0);

      // Forwarding
      alu_op(5'b00000, 32'h10, 32'h0, 1'b0);           tick();
      alu_op(5'b00000, 32'hDEAD, 32'hBEEF, 1'b0);
      bus.ForwardAE = 2'b10; bus.ForwardBE = 2'b01; bus.ResultW = 32'h20;
      tick();
      check("fwd_alu", bus.ALUResultM, 32'h30);
      check("fwd_wd",  bus.WriteDataM, 32'h20);
      alu_op(5'b00000, 32'd3, 32'd4, 1'b0);
      bus.ForwardAE = 2'b11; bus.ResultW = 32'd100;
      tick();
      check("fwd_11",  bus.ALUResultM, 32'd7);

      // Branches
      idle();
      bus.BranchE = 1'b1; bus.PCE = 32'h100; bus.ImmExtE = 32'hFFFF_FFF8;
      bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 32'd1; bus.funct3E = 3'b100;
      #1;
      check("blt_src", {31'd0, bus.PCSrcE}, 32'd1);
      check("blt_tgt", bus.PCTargetE, 32'h0000_00F8);
      bus.funct3E = 3'b110; #1;
      check("bltu_src", {31'd0, bus.PCSrcE}, 32'd0);
      bus.funct3E = 3'b101; #1;
      check("bge_src", {31'd0, bus.PCSrcE}, 32'd0);
      bus.funct3E = 3'b010; #1;
      check("f3_010",  {31'd0, bus.PCSrcE}, 32'd0);
      tick();

      // JALR
      idle();
      bus.JumpE = 1'b1; bus.JalrE = 1'b1; bus.RD1E = 32'h1003; bus.ImmExtE = 32'd2;
      bus.PCPlus4E = 32'h208; bus.RegWriteE = 1'b1; bus.RdE = 5'd1; bus.ResultSrcE = 2'd2;
      #1;
      check("jalr_tgt", bus.PCTargetE, 32'h1004);
      check("jalr_src", {31'd0, bus.PCSrcE}, 32'd1);
      tick();
      check("jalr_pc4", bus.PCPlus4M, 32'h208);

      // Stall
      alu_op(5'b00000, 32'h11, 32'h22, 1'b0);
      bus.RdE = 5'd5; bus.RegWriteE = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         alu_op(5'b00011, 32'h100 << i, 32'h7, 1'b0);
         bus.EnM = 1'b0; bus.RdE = 5'(i + 10);
         tick();
         check("stall_alu", bus.ALUResultM, 32'h33);
         check("stall_rd",  {27'd0, bus.RdM}, 32'd5);
      end
      bus.EnM = 1'b1;
      tick();
      check("resume", bus.ALUResultM, 32'h407);
      bus.EnM = 1'b0; rst = 1'b0;
      tick();
      check("stall_rst", bus.ALUResultM, 32'd0);
      check("stall_rst_rd", {27'd0, bus.RdM}, 32'd0);
      rst = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] a, b;
         a = $urandom; b = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 3)) - 32'd1;
         if ($urandom_range(0, 3) == 0) b = a;
         bus.EnM         = ($urandom_range(0, 9) != 0);
         rst             = ($urandom_range(0, 49) != 0);
         bus.RegWriteE   = 1'($urandom);
         bus.MemWriteE   = 1'($urandom);
         bus.JumpE       = ($urandom_range(0, 7) == 0);
         bus.BranchE     = 1'($urandom);
         bus.ALUSrcE     = 1'($urandom);
         bus.JalrE       = 1'($urandom);
         bus.ResultSrcE  = 2'($urandom);
         bus.ALUControlE = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 10));
         bus.funct3E     = 3'($urandom);
         bus.PCE         = $urandom;
         bus.PCPlus4E    = bus.PCE + 32'd4;
         bus.ImmExtE     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         bus.RD1E        = a;
         bus.RD2E        = b;
         bus.RdE         = 5'($urandom);
         bus.ForwardAE   = 2'($urandom);
         bus.ForwardBE   = 2'($urandom);
         bus.ResultW     = ($urandom_range(0, 3) == 0) ? a : $urandom;
         tick();
      end
      rst = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
